// File: rtl/c1541_sd_pkg.sv
// Shared types and constants for the c1541 SD channel arbiter.
package c1541_sd_pkg;

  typedef enum logic [1:0] {
    SA_IDLE,
    SA_REQ,
    SA_XFER,
    SA_DONE
  } sa_state_e;

  localparam int SD_LBA_W  = 32;
  localparam int SD_ADDR_W = 9;
  localparam int SD_DATA_W = 8;

  // Increment modulo n, used for the round-robin pointer.
  function automatic int sd_wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/c1541_rr_pick.sv
// Combinational round-robin finder: returns the first set pending bit
// at or after the pointer, wrapping around, plus a valid flag.
module c1541_rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  pending_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  // Rotate so that bit 0 corresponds to the pointer position.
  logic [N-1:0] rot;
  assign rot     = N'({pending_i, pending_i} >> ptr_i);
  assign valid_o = |pending_i;

  // Scan from the far end so the smallest offset from the pointer wins.
  always_comb begin
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        idx_o = PW'((int'(ptr_i) + k) % N);
      end
    end
  end

endmodule

// File: rtl/c1541_sd_arbiter.sv
// Shares one host SD block channel between several c1541 track blocks.
// Requests are serialised round-robin; ack and buffer strobes are routed
// only to the granted client; a stuck host is released by a timeout.
module c1541_sd_arbiter
  import c1541_sd_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int TIMEOUT_W   = 24
) (
  input  logic                              sd_clk,
  input  logic                              reset,
  input  logic [SD_LBA_W*NUM_CLIENTS-1:0]   cl_lba,
  input  logic [NUM_CLIENTS-1:0]            cl_rd,
  input  logic [NUM_CLIENTS-1:0]            cl_wr,
  output logic [NUM_CLIENTS-1:0]            cl_ack,
  input  logic [SD_DATA_W*NUM_CLIENTS-1:0]  cl_buff_din,
  output logic [NUM_CLIENTS-1:0]            cl_buff_wr,
  output logic [SD_ADDR_W-1:0]              cl_buff_addr,
  output logic [SD_DATA_W-1:0]              cl_buff_dout,
  output logic [SD_LBA_W-1:0]               host_lba,
  output logic [1:0]                        host_id,
  output logic                              host_rd,
  output logic                              host_wr,
  input  logic                              host_ack,
  input  logic [SD_ADDR_W-1:0]              host_buff_addr,
  input  logic [SD_DATA_W-1:0]              host_buff_dout,
  output logic [SD_DATA_W-1:0]              host_buff_din,
  input  logic                              host_buff_wr,
  output logic                              timeout_err
);

  localparam int PW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  sa_state_e              state_q, state_d;
  logic [PW-1:0]          grant_q, grant_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_CLIENTS-1:0] rd_q, wr_q;
  logic [SD_LBA_W-1:0]    host_lba_q, host_lba_d;
  logic [1:0]             host_id_q, host_id_d;
  logic                   host_rd_q, host_rd_d;
  logic                   host_wr_q, host_wr_d;
  logic                   timeout_q, timeout_d;

  logic [PW-1:0]          pick_idx;
  logic                   pick_valid;
  logic [SD_LBA_W-1:0]    pick_lba;
  logic                   pick_wr;
  logic [TIMEOUT_W-1:0]   cnt_inc;
  logic                   timeout_hit;
  logic [PW-1:0]          ptr_next;

  c1541_rr_pick #(
    .N  (NUM_CLIENTS),
    .PW (PW)
  ) u_pick (
    .pending_i (rd_q | wr_q),
    .ptr_i     (ptr_q),
    .idx_o     (pick_idx),
    .valid_o   (pick_valid)
  );

  // Counter saturates at all-ones; reaching all-ones ends the request.
  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign timeout_hit = &cnt_inc;
  assign ptr_next    = PW'(sd_wrap_inc(int'(grant_q), NUM_CLIENTS));

  // Select LBA and write flag of the client the picker chose.
  always_comb begin
    pick_lba = '0;
    pick_wr  = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (pick_idx == PW'(i)) begin
        pick_lba = cl_lba[SD_LBA_W*i +: SD_LBA_W];
        pick_wr  = wr_q[i];
      end
    end
  end

  // State and registered outputs; client request levels get one register stage.
  always_ff @(posedge sd_clk) begin
    if (reset) begin
      state_q    <= SA_IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      host_lba_q <= '0;
      host_id_q  <= '0;
      host_rd_q  <= 1'b0;
      host_wr_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      rd_q       <= cl_rd;
      wr_q       <= cl_wr;
      host_lba_q <= host_lba_d;
      host_id_q  <= host_id_d;
      host_rd_q  <= host_rd_d;
      host_wr_q  <= host_wr_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state decision; host ack takes priority over the timeout in REQ.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SA_IDLE: if (pick_valid) state_d = SA_REQ;
      SA_REQ: begin
        if (host_ack)         state_d = SA_XFER;
        else if (timeout_hit) state_d = SA_IDLE;
      end
      SA_XFER: if (!host_ack) state_d = SA_DONE;
      SA_DONE: state_d = SA_IDLE;
      default: state_d = SA_IDLE;
    endcase
  end

  // Next values of grant, pointer, timeout counter and host request outputs.
  always_comb begin
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    cnt_d      = '0;
    host_lba_d = host_lba_q;
    host_id_d  = host_id_q;
    host_rd_d  = host_rd_q;
    host_wr_d  = host_wr_q;
    timeout_d  = 1'b0;
    case (state_q)
      SA_IDLE: begin
        if (pick_valid) begin
          grant_d    = pick_idx;
          host_lba_d = pick_lba;
          host_id_d  = 2'(pick_idx);
          host_wr_d  = pick_wr;
          host_rd_d  = ~pick_wr;
        end
      end
      SA_REQ: begin
        if (host_ack) begin
          host_rd_d = 1'b0;
          host_wr_d = 1'b0;
        end else if (timeout_hit) begin
          host_rd_d = 1'b0;
          host_wr_d = 1'b0;
          timeout_d = 1'b1;
          ptr_d     = ptr_next;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      SA_DONE: ptr_d = ptr_next;
      default: ;
    endcase
  end

  // Route host ack and write strobe to the granted client only, during XFER.
  always_comb begin
    cl_ack        = '0;
    cl_buff_wr    = '0;
    host_buff_din = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (grant_q == PW'(i)) begin
        cl_ack[i]     = (state_q == SA_XFER) & host_ack;
        cl_buff_wr[i] = (state_q == SA_XFER) & host_buff_wr;
        host_buff_din = cl_buff_din[SD_DATA_W*i +: SD_DATA_W];
      end
    end
  end

  assign cl_buff_addr = host_buff_addr;
  assign cl_buff_dout = host_buff_dout;
  assign host_lba     = host_lba_q;
  assign host_id      = host_id_q;
  assign host_rd      = host_rd_q;
  assign host_wr      = host_wr_q;
  assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_c1541_sd_arbiter.sv
// Bench for c1541_sd_arbiter: directed sequences, a vector table and a
// randomized run against a round-robin scoreboard.
module tb_c1541_sd_arbiter;

  localparam int NC = 2;

  logic        sd_clk = 1'b0;
  logic        reset;
  logic [63:0] cl_lba;
  logic [1:0]  cl_rd, cl_wr;
  logic [1:0]  cl_ack, cl_buff_wr;
  logic [15:0] cl_buff_din;
  logic [8:0]  cl_buff_addr;
  logic [7:0]  cl_buff_dout;
  logic [31:0] host_lba;
  logic [1:0]  host_id;
  logic        host_rd, host_wr;
  logic        host_ack;
  logic [8:0]  host_buff_addr;
  logic [7:0]  host_buff_dout;
  logic [7:0]  host_buff_din;
  logic        host_buff_wr;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  c1541_sd_arbiter #(.NUM_CLIENTS(NC), .TIMEOUT_W(4)) dut (
    .sd_clk(sd_clk), .reset(reset), .cl_lba(cl_lba), .cl_rd(cl_rd), .cl_wr(cl_wr),
    .cl_ack(cl_ack), .cl_buff_din(cl_buff_din), .cl_buff_wr(cl_buff_wr),
    .cl_buff_addr(cl_buff_addr), .cl_buff_dout(cl_buff_dout), .host_lba(host_lba),
    .host_id(host_id), .host_rd(host_rd), .host_wr(host_wr), .host_ack(host_ack),
    .host_buff_addr(host_buff_addr), .host_buff_dout(host_buff_dout),
    .host_buff_din(host_buff_din), .host_buff_wr(host_buff_wr), .timeout_err(timeout_err)
  );

  always #5 sd_clk = ~sd_clk;

  // Per-client data each drive would offer the host at a given buffer address.
  function automatic logic [7:0] pat(input int i, input logic [8:0] a);
    return (i == 1) ? (a[7:0] ^ 8'h5A) : (~a[7:0] ^ 8'h33);
  endfunction

  assign cl_buff_din = {pat(1, host_buff_addr), pat(0, host_buff_addr)};

  task automatic step();
    @(posedge sd_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; cl_rd = '0; cl_wr = '0; host_ack = 1'b0; host_buff_wr = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  // Bounded wait for a host request to appear.
  task automatic wait_req(input int maxc);
    int n;
    n = 0;
    while (!(host_rd | host_wr) && n < maxc) begin
      step();
      n++;
    end
    chk("req_wait", 32'(host_rd | host_wr), 32'd1);
  endtask

  // Act as the host for one transfer to the expected client; drops that
  // client's request together with the ack falling edge.
  task automatic serve(input int id, input bit exp_wr, input logic [31:0] exp_lba,
                       input int nbytes, input bit rnd);
    logic [1:0] oh;
    logic [8:0] a;
    bit         w;
    oh = (id == 1) ? 2'b10 : 2'b01;
    chk("host_id", 32'(host_id), 32'(id));
    chk("host_wr", 32'(host_wr), 32'(exp_wr));
    chk("host_rd", 32'(host_rd), 32'(!exp_wr));
    chk("host_lba", host_lba, exp_lba);
    host_ack = 1'b1;
    step();
    chk("req_drop", 32'({host_rd, host_wr}), 32'd0);
    for (int i = 0; i < nbytes; i++) begin
      a = rnd ? 9'($urandom_range(0, 511)) : 9'(i);
      w = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      host_buff_addr = a;
      host_buff_dout = 8'($urandom);
      host_buff_wr   = w;
      #1;
      chk("cl_ack", 32'(cl_ack), 32'(oh));
      chk("cl_buff_wr", 32'(cl_buff_wr), w ? 32'(oh) : 32'd0);
      chk("cl_buff_addr", 32'(cl_buff_addr), 32'(a));
      chk("cl_buff_dout", 32'(cl_buff_dout), 32'(host_buff_dout));
      chk("host_buff_din", 32'(host_buff_din), 32'(pat(id, a)));
      step();
    end
    host_ack = 1'b0;
    host_buff_wr = 1'b0;
    if (id == 1) begin cl_rd[1] = 1'b0; cl_wr[1] = 1'b0; end
    else         begin cl_rd[0] = 1'b0; cl_wr[0] = 1'b0; end
    #1;
    chk("ack_fall", 32'(cl_ack), 32'd0);
  endtask

  typedef struct {
    logic [1:0] rd;
    logic [1:0] wr;
    int         exp_id;
    bit         exp_wr;
  } vec_t;

  // Scoreboard state for the randomized run.
  bit          waiting [NC];
  bit          want_wr [NC];
  logic [31:0] lba_m   [NC];

  task automatic raise(input int i);
    bit w;
    lba_m[i] = $urandom;
    cl_lba[32*i +: 32] = lba_m[i];
    w = 1'($urandom_range(0, 1));
    want_wr[i] = w;
    if (w) begin cl_wr[i] = 1'b1; cl_rd[i] = 1'($urandom_range(0, 1)); end
    else   begin cl_rd[i] = 1'b1; end
    waiting[i] = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int   n, pulses, ptr_m, id, other, d;
    logic [31:0] lba_e;

    tbl[0] = '{rd: 2'b01, wr: 2'b00, exp_id: 0, exp_wr: 1'b0};
    tbl[1] = '{rd: 2'b11, wr: 2'b00, exp_id: 1, exp_wr: 1'b0};
    tbl[2] = '{rd: 2'b11, wr: 2'b00, exp_id: 0, exp_wr: 1'b0};
    tbl[3] = '{rd: 2'b00, wr: 2'b01, exp_id: 0, exp_wr: 1'b1};
    tbl[4] = '{rd: 2'b01, wr: 2'b01, exp_id: 0, exp_wr: 1'b1};
    tbl[5] = '{rd: 2'b10, wr: 2'b01, exp_id: 1, exp_wr: 1'b0};
    tbl[6] = '{rd: 2'b00, wr: 2'b10, exp_id: 1, exp_wr: 1'b1};
    tbl[7] = '{rd: 2'b10, wr: 2'b01, exp_id: 0, exp_wr: 1'b1};

    cl_lba = '0; host_buff_addr = '0; host_buff_dout = '0;
    do_reset();

    // Reset state.
    chk("rst_host_rd", 32'(host_rd), 0);
    chk("rst_host_wr", 32'(host_wr), 0);
    chk("rst_host_lba", host_lba, 0);
    chk("rst_host_id", 32'(host_id), 0);
    chk("rst_cl_ack", 32'(cl_ack), 0);
    chk("rst_cl_buff_wr", 32'(cl_buff_wr), 0);
    chk("rst_timeout", 32'(timeout_err), 0);

    // Single client 0 read: two-cycle latency, 512 bytes to client 0 only.
    cl_lba[31:0] = 32'h0000_0A45;
    cl_rd = 2'b01;
    step();
    chk("lat_1cyc", 32'(host_rd), 0);
    step();
    chk("lat_2cyc", 32'(host_rd), 1);
    serve(0, 1'b0, 32'h0000_0A45, 512, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_idle", 32'({host_rd, host_wr, cl_ack}), 0);
    end

    // Concurrent reads from pointer 0, then client 0 re-requests immediately.
    do_reset();
    cl_lba = {32'h0000_1111, 32'h0000_0000};
    cl_rd = 2'b11;
    wait_req(4);
    serve(0, 1'b0, 32'h0000_0000, 4, 1'b0);
    step();
    cl_rd[0] = 1'b1;
    chk("done_gap1", 32'(host_rd), 0);
    step();
    chk("done_gap2", 32'(host_rd), 0);
    step();
    chk("next_req_edge3", 32'(host_rd), 1);
    serve(1, 1'b0, 32'h0000_1111, 4, 1'b0);
    step(); step(); step();
    chk("rerequest_served", 32'(host_rd), 1);
    serve(0, 1'b0, 32'h0000_0000, 4, 1'b0);
    step(); step(); step();

    // Client 1 write: host sees client 1 data for all addresses.
    cl_lba[63:32] = 32'h0001_2345;
    cl_wr = 2'b10;
    wait_req(4);
    serve(1, 1'b1, 32'h0001_2345, 512, 1'b0);
    step(); step(); step();

    // Timeout: client drops its level during REQ, host never acks.
    cl_lba[31:0] = 32'h0000_0777;
    cl_rd = 2'b01;
    step(); step();
    chk("to_req", 32'(host_rd), 1);
    cl_rd = 2'b00;
    n = 0; pulses = 0;
    while (host_rd && n < 40) begin
      n++;
      if (timeout_err) pulses++;
      step();
    end
    chk("to_req_cycles", 32'(n), 15);
    chk("to_pulse", 32'(timeout_err), 1);
    if (timeout_err) pulses++;
    step();
    chk("to_pulse_end", 32'(timeout_err), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_idle", 32'({host_rd, host_wr, timeout_err}), 0);
    end
    chk("to_pulses", 32'(pulses), 1);

    // Reset mid-transfer at address 200, with a stuck host ack afterwards.
    cl_lba[31:0] = 32'h00FF_00AA;
    cl_rd = 2'b01;
    wait_req(4);
    host_ack = 1'b1;
    step();
    for (int i = 0; i < 200; i++) begin
      host_buff_addr = 9'(i); host_buff_wr = 1'b1;
      step();
    end
    host_buff_addr = 9'd200;
    #1;
    chk("mid_xfer_ack", 32'(cl_ack), 32'd1);
    reset = 1'b1; cl_rd = 2'b00;
    step();
    chk("rst_mid_ack", 32'(cl_ack), 0);
    chk("rst_mid_req", 32'({host_rd, host_wr}), 0);
    chk("rst_mid_bwr", 32'(cl_buff_wr), 0);
    reset = 1'b0;
    step();
    chk("spurious_ack", 32'({cl_ack, cl_buff_wr}), 0);
    host_ack = 1'b0; host_buff_wr = 1'b0;
    step();
    cl_lba[63:32] = 32'hABCD_0001;
    cl_wr = 2'b10;
    wait_req(4);
    serve(1, 1'b1, 32'hABCD_0001, 8, 1'b0);
    step(); step(); step();

    // Vector table from a fresh reset (pointer 0).
    do_reset();
    for (int e = 0; e < 8; e++) begin
      cl_lba = {32'hC0DE_0000 | 32'(e << 4) | 32'd1, 32'hC0DE_0000 | 32'(e << 4)};
      lba_e  = 32'hC0DE_0000 | 32'(e << 4) | 32'(tbl[e].exp_id);
      cl_rd = tbl[e].rd;
      cl_wr = tbl[e].wr;
      wait_req(6);
      serve(tbl[e].exp_id, tbl[e].exp_wr, lba_e, 3, 1'b1);
      cl_rd = '0; cl_wr = '0;
      step(); step(); step();
      chk("tbl_idle", 32'({host_rd, host_wr}), 0);
    end

    // Randomized traffic against a round-robin scoreboard.
    do_reset();
    ptr_m = 0;
    for (int i = 0; i < NC; i++) waiting[i] = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (!waiting[0] && !waiting[1]) begin
        d = $urandom_range(1, 3);
        if (d[0]) raise(0);
        if (d[1]) raise(1);
      end
      wait_req(8);
      id = -1;
      for (int k = 0; k < NC; k++) begin
        if (id < 0 && waiting[(ptr_m + k) % NC]) id = (ptr_m + k) % NC;
      end
      if (id < 0) id = 0;
      other = 1 - id;
      d = $urandom_range(0, 3);
      for (int k = 0; k < d; k++) begin
        if (!waiting[other] && $urandom_range(0, 1) == 1) raise(other);
        step();
      end
      serve(id, want_wr[id], lba_m[id], $urandom_range(1, 6), 1'b1);
      waiting[id] = 1'b0;
      ptr_m = (id + 1) % NC;
      step();
      if ($urandom_range(0, 2) == 0) raise(id);
    end
    cl_rd = '0; cl_wr = '0;
    step(); step(); step(); step();
    chk("final_idle", 32'({host_rd, host_wr, cl_ack}), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
